// File: rtl/am2909_next_addr_ctrl_pkg.sv
// Shared types for the Am2909 next-address controller: opcode set and
// Am2909 source-select encodings.
package am2909_next_addr_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CONT = 4'd1,
    OP_JMP  = 4'd2,
    OP_CJP  = 4'd3,
    OP_JSB  = 4'd4,
    OP_CJS  = 4'd5,
    OP_RTN  = 4'd6,
    OP_CRTN = 4'd7,
    OP_LDCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_LOOP = 4'd10,
    OP_PUSH = 4'd11,
    OP_LDAR = 4'd12,
    OP_JAR  = 4'd13,
    OP_CJAR = 4'd14,
    OP_CHLD = 4'd15
  } opcode_e;

  localparam logic [1:0] SRC_UPC = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

endpackage

// File: rtl/am2909_ctrl_defs.vh
// Opcode and source-select encodings for the Am2909 next-address controller,
// shared with the microassembler and benches that prefer textual macros.
`ifndef AM2909_CTRL_DEFS_VH
`define AM2909_CTRL_DEFS_VH

`define AM2909_OP_JZ   4'd0
`define AM2909_OP_CONT 4'd1
`define AM2909_OP_JMP  4'd2
`define AM2909_OP_CJP  4'd3
`define AM2909_OP_JSB  4'd4
`define AM2909_OP_CJS  4'd5
`define AM2909_OP_RTN  4'd6
`define AM2909_OP_CRTN 4'd7
`define AM2909_OP_LDCT 4'd8
`define AM2909_OP_RPCT 4'd9
`define AM2909_OP_LOOP 4'd10
`define AM2909_OP_PUSH 4'd11
`define AM2909_OP_LDAR 4'd12
`define AM2909_OP_JAR  4'd13
`define AM2909_OP_CJAR 4'd14
`define AM2909_OP_CHLD 4'd15

`define AM2909_S_UPC 2'b00
`define AM2909_S_AR  2'b01
`define AM2909_S_STK 2'b10
`define AM2909_S_D   2'b11

`endif

// File: rtl/am2909_next_addr_ctrl_seq_stack_tracker.sv
// Shadow copy of the Am2909 file depth; refuses pushes when full and pops when
// empty, latching a sticky error instead.
module seq_stack_tracker #(
  parameter int STACK_DEPTH = 4,
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [DW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;

  assign full_o  = (depth_q == DW'(STACK_DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign err_o   = err_q;

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (clear_i) begin
      depth_d = '0;
    end else if (push_i) begin
      if (full_o) err_d = 1'b1;
      else        depth_d = depth_q + DW'(1);
    end else if (pop_i) begin
      if (empty_o) err_d = 1'b1;
      else         depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/am2909_next_addr_ctrl.sv
// Next-address controller for cascaded Am2909 slices: combinational opcode
// decode, loop counter, and shadow stack-depth tracking.
module am2909_next_addr_ctrl
  import am2909_next_addr_ctrl_pkg::*;
#(
  parameter  int CNT_WIDTH   = 8,
  parameter  int STACK_DEPTH = 4,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 CP,
  input  logic                 RST,
  input  logic [3:0]           I,
  input  logic                 CC,
  input  logic                 CCEN,
  input  logic [CNT_WIDTH-1:0] CNT_D,
  output logic [1:0]           S,
  output logic                 FE,
  output logic                 PUP,
  output logic                 RE,
  output logic                 ZERO,
  output logic                 CN,
  output logic                 CNT_ZERO,
  output logic [DW-1:0]        DEPTH,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 ERR
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pass;
  logic                 push_req, pop_req, clear_req;
  opcode_e              op;

  assign op       = opcode_e'(I);
  assign pass     = ~CCEN | CC;
  assign CNT_ZERO = (cnt_q == '0);

  always_comb begin
    S         = SRC_UPC;
    RE        = 1'b1;
    ZERO      = 1'b1;
    CN        = 1'b1;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    clear_req = 1'b0;
    cnt_d     = cnt_q;
    if (RST) begin
      ZERO  = 1'b0;
      cnt_d = '0;
    end else begin
      case (op)
        OP_JZ:   begin ZERO = 1'b0; clear_req = 1'b1; end
        OP_CONT: ;
        OP_JMP:  S = SRC_D;
        OP_CJP:  if (pass) S = SRC_D;
        OP_JSB:  begin S = SRC_D; push_req = 1'b1; end
        OP_CJS:  if (pass) begin S = SRC_D; push_req = 1'b1; end
        OP_RTN:  begin S = SRC_STK; pop_req = 1'b1; end
        OP_CRTN: if (pass) begin S = SRC_STK; pop_req = 1'b1; end
        OP_LDCT: cnt_d = CNT_D;
        OP_RPCT: if (!CNT_ZERO) begin S = SRC_D; cnt_d = cnt_q - CNT_WIDTH'(1); end
        // Loop body start stays on the stack while iterating; popped on exit.
        OP_LOOP: begin
          if (!CNT_ZERO) begin
            S     = SRC_STK;
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            pop_req = 1'b1;
          end
        end
        OP_PUSH: begin push_req = 1'b1; if (pass) cnt_d = CNT_D; end
        OP_LDAR: RE = 1'b0;
        OP_JAR:  S = SRC_AR;
        OP_CJAR: if (pass) S = SRC_AR;
        OP_CHLD: if (pass) CN = 1'b0;
        default: ;
      endcase
    end
  end

  // Stack operations the tracker would reject never reach the Am2909 file.
  assign FE  = ~((push_req & ~FULL) | (pop_req & ~EMPTY));
  assign PUP = ~pop_req;

  always_ff @(posedge CP) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  seq_stack_tracker #(
    .STACK_DEPTH (STACK_DEPTH),
    .DW          (DW)
  ) u_stack (
    .clk     (CP),
    .srst    (RST),
    .clear_i (clear_req),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .depth_o (DEPTH),
    .full_o  (FULL),
    .empty_o (EMPTY),
    .err_o   (ERR)
  );

endmodule

// File: tb/tb_am2909_next_addr_ctrl.sv
// Bench for the Am2909 next-address controller: directed scenarios with
// literal expectations plus randomized opcodes against a behavioural model.
module tb_am2909_next_addr_ctrl;

  localparam int SD = 4;

  logic       CP = 1'b0;
  logic       RST, CC, CCEN;
  logic [3:0] I;
  logic [7:0] CNT_D;
  logic [1:0] S;
  logic       FE, PUP, RE, ZERO, CN, CNT_ZERO, FULL, EMPTY, ERR;
  logic [2:0] DEPTH;

  int checks   = 0;
  int failures = 0;

  // Model state and the effects pending for the next edge.
  int m_cnt, m_depth, m_err;
  int nx_cnt, nx_push, nx_pop, nx_clr;

  am2909_next_addr_ctrl #(.CNT_WIDTH(8), .STACK_DEPTH(SD)) dut (
    .CP(CP), .RST(RST), .I(I), .CC(CC), .CCEN(CCEN), .CNT_D(CNT_D),
    .S(S), .FE(FE), .PUP(PUP), .RE(RE), .ZERO(ZERO), .CN(CN),
    .CNT_ZERO(CNT_ZERO), .DEPTH(DEPTH), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CP = ~CP;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one microinstruction, then compare every output with the model.
  task automatic apply(input int op, input int cc, input int ccen, input int d, input int rst);
    int pass, e_s, e_re, e_zero, e_cn, e_fe, e_pup;
    I = 4'(op); CC = cc[0]; CCEN = ccen[0]; CNT_D = 8'(d); RST = rst[0];
    #2;
    pass = (!ccen || cc) ? 1 : 0;
    e_s = 0; e_re = 1; e_zero = 1; e_cn = 1;
    nx_push = 0; nx_pop = 0; nx_clr = 0; nx_cnt = m_cnt;
    if (rst != 0) begin
      e_zero = 0;
    end else begin
      case (op)
        0:  begin e_zero = 0; nx_clr = 1; end
        2:  e_s = 3;
        3:  if (pass != 0) e_s = 3;
        4:  begin e_s = 3; nx_push = 1; end
        5:  if (pass != 0) begin e_s = 3; nx_push = 1; end
        6:  begin e_s = 2; nx_pop = 1; end
        7:  if (pass != 0) begin e_s = 2; nx_pop = 1; end
        8:  nx_cnt = d;
        9:  if (m_cnt > 0) begin e_s = 3; nx_cnt = m_cnt - 1; end
        10: if (m_cnt > 0) begin e_s = 2; nx_cnt = m_cnt - 1; end else nx_pop = 1;
        11: begin nx_push = 1; if (pass != 0) nx_cnt = d; end
        12: e_re = 0;
        13: e_s = 1;
        14: if (pass != 0) e_s = 1;
        15: if (pass != 0) e_cn = 0;
        default: ;
      endcase
    end
    e_fe  = ((nx_push != 0 && m_depth < SD) || (nx_pop != 0 && m_depth > 0)) ? 0 : 1;
    e_pup = (nx_pop != 0) ? 0 : 1;
    chk("S", int'(S), e_s);
    chk("FE", int'(FE), e_fe);
    chk("PUP", int'(PUP), e_pup);
    chk("RE", int'(RE), e_re);
    chk("ZERO", int'(ZERO), e_zero);
    chk("CN", int'(CN), e_cn);
    chk("CNT_ZERO", int'(CNT_ZERO), (m_cnt == 0) ? 1 : 0);
    chk("DEPTH", int'(DEPTH), m_depth);
    chk("FULL", int'(FULL), (m_depth == SD) ? 1 : 0);
    chk("EMPTY", int'(EMPTY), (m_depth == 0) ? 1 : 0);
    chk("ERR", int'(ERR), m_err);
  endtask

  task automatic tick();
    @(posedge CP);
    if (RST) begin
      m_cnt = 0; m_depth = 0; m_err = 0;
    end else begin
      m_cnt = nx_cnt;
      if (nx_clr != 0) m_depth = 0;
      else if (nx_push != 0) begin
        if (m_depth == SD) m_err = 1; else m_depth++;
      end else if (nx_pop != 0) begin
        if (m_depth == 0) m_err = 1; else m_depth--;
      end
    end
    #1;
  endtask

  initial begin
    m_cnt = 0; m_depth = 0; m_err = 0;
    I = 4'd1; CC = 1'b0; CCEN = 1'b0; CNT_D = 8'd0; RST = 1'b1;
    @(posedge CP); #1;

    // Reset, then continue.
    apply(1, 0, 0, 0, 1);
    chk("lit_rst_zero", int'(ZERO), 0);
    chk("lit_rst_s", int'(S), 0);
    tick();
    apply(1, 0, 0, 0, 0);
    chk("lit_post_rst_depth", int'(DEPTH), 0);
    chk("lit_post_rst_cntzero", int'(CNT_ZERO), 1);
    chk("lit_post_rst_err", int'(ERR), 0);
    tick();

    // Conditional call, then return.
    apply(5, 0, 1, 0, 0);
    chk("lit_cjs_fail_s", int'(S), 0);
    chk("lit_cjs_fail_fe", int'(FE), 1);
    tick();
    apply(5, 1, 1, 0, 0);
    chk("lit_cjs_pass_s", int'(S), 3);
    chk("lit_cjs_pass_fe", int'(FE), 0);
    chk("lit_cjs_pass_pup", int'(PUP), 1);
    tick();
    apply(6, 0, 0, 0, 0);
    chk("lit_rtn_depth", int'(DEPTH), 1);
    chk("lit_rtn_s", int'(S), 2);
    chk("lit_rtn_fe", int'(FE), 0);
    chk("lit_rtn_pup", int'(PUP), 0);
    tick();

    // Overflow on the fifth call, underflow on the fifth return.
    for (int k = 0; k < 5; k++) begin
      apply(4, 0, 0, 0, 0);
      chk("lit_jsb_depth", int'(DEPTH), k < 4 ? k : 4);
      if (k == 4) begin
        chk("lit_jsb_full", int'(FULL), 1);
        chk("lit_jsb_full_fe", int'(FE), 1);
        chk("lit_jsb_full_s", int'(S), 3);
      end
      tick();
    end
    apply(1, 0, 0, 0, 0);
    chk("lit_ovf_err", int'(ERR), 1);
    chk("lit_ovf_depth", int'(DEPTH), 4);
    tick();
    for (int k = 0; k < 4; k++) begin apply(6, 0, 0, 0, 0); tick(); end
    apply(6, 0, 0, 0, 0);
    chk("lit_udf_empty", int'(EMPTY), 1);
    chk("lit_udf_fe", int'(FE), 1);
    tick();
    apply(1, 0, 0, 0, 0);
    chk("lit_udf_err", int'(ERR), 1);
    tick();

    // Counted loop with PUSH / LOOP.
    apply(1, 0, 0, 0, 1); tick();
    apply(11, 0, 0, 3, 0); tick();
    for (int k = 0; k < 4; k++) begin
      apply(10, 0, 0, 0, 0);
      chk("lit_loop_s", int'(S), k < 3 ? 2 : 0);
      if (k == 3) begin
        chk("lit_loop_exit_fe", int'(FE), 0);
        chk("lit_loop_exit_pup", int'(PUP), 0);
      end
      tick();
    end
    apply(12, 0, 0, 0, 0);
    chk("lit_loop_done_depth", int'(DEPTH), 0);
    chk("lit_loop_done_cz", int'(CNT_ZERO), 1);
    chk("lit_ldar_re", int'(RE), 0);
    tick();
    apply(13, 0, 0, 0, 0); chk("lit_jar_s", int'(S), 1); tick();
    apply(15, 1, 1, 0, 0); chk("lit_chld_cn", int'(CN), 0); tick();
    apply(15, 0, 1, 0, 0); chk("lit_chld_fail_cn", int'(CN), 1); tick();

    // Repeat-on-counter.
    apply(8, 0, 0, 2, 0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(9, 0, 0, 0, 0);
      chk("lit_rpct_s", int'(S), k < 2 ? 3 : 0);
      tick();
    end

    // Reset mid-subroutine discards counter and depth.
    apply(8, 0, 0, 5, 0); tick();
    for (int k = 0; k < 3; k++) begin apply(4, 0, 0, 0, 0); tick(); end
    apply(1, 0, 0, 0, 1);
    chk("lit_pre_rst_depth", int'(DEPTH), 3);
    chk("lit_pre_rst_cz", int'(CNT_ZERO), 0);
    tick();
    apply(1, 0, 0, 0, 0);
    chk("lit_mid_rst_depth", int'(DEPTH), 0);
    chk("lit_mid_rst_cz", int'(CNT_ZERO), 1);
    tick();

    // Randomized opcodes against the model.
    for (int n = 0; n < 600; n++) begin
      apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            ($urandom_range(0, 39) == 0) ? 1 : 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
